// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer
package fetch_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    HALT  = 3'd5
  } state_t;
  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_PC_RANGE = 2'd1;
  localparam logic [1:0] FC_FILL = 2'd2;
  localparam logic [1:0] FC_LOAD_OVF = 2'd3;
  localparam logic [31:0] FILL_WORD = 32'hDEADBEEF;
  localparam int DEF_MEM_SIZE = 1024;
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: loads a program into instruction memory and streams fetched instructions to decode
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic        prog_valid,
  output logic        prog_ready,
  input  logic [31:0] prog_data,
  input  logic        prog_last,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_load,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [2:0]  state,
  output logic        fault,
  output logic [1:0]  fault_code
);
  localparam logic [31:0] SIZE = 32'(MEM_SIZE);
  localparam logic [31:0] LAST = SIZE - 32'd1;
  state_t st, nxt;
  logic [31:0] pc, load_ptr;
  assign state = st;
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else st <= nxt;
  end
  // next-state decode; redirect outranks every other exit from the fetch states
  always_comb begin
    nxt = st;
    case (st)
      IDLE, HALT: nxt = load_req ? LOAD : start ? ISSUE : st;
      LOAD:       nxt = (mem_load && (prog_last || load_ptr == LAST)) ? IDLE : LOAD;
      ISSUE:      nxt = redirect_valid ? ISSUE : (pc >= SIZE) ? HALT : WAIT;
      WAIT:       nxt = redirect_valid ? ISSUE : (mem_rdata == FILL_WORD) ? HALT : HOLD;
      HOLD:       nxt = (redirect_valid || inst_ready) ? ISSUE : HOLD;
      default:    nxt = IDLE;
    endcase
  end
  // memory-side outputs; reset forces st to IDLE so these drop immediately
  always_comb begin
    prog_ready = st == LOAD;
    mem_load = prog_ready && prog_valid;
    mem_addr = prog_ready ? load_ptr : pc;
    mem_wdata = prog_data;
  end
  // datapath: pc, load pointer, instruction capture and sticky fault (first cause kept)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      load_ptr <= '0;
      inst <= '0;
      inst_pc <= '0;
      inst_valid <= 1'b0;
      fault <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      case (st)
        IDLE, HALT: begin
          if (load_req) load_ptr <= '0;
          else if (start) pc <= RESET_PC;
          if (load_req || start) begin
            fault <= 1'b0;
            fault_code <= FC_NONE;
          end
        end
        LOAD: if (mem_load) begin
          load_ptr <= load_ptr + 32'd1;
          if (!prog_last && load_ptr == LAST) begin
            fault <= 1'b1;
            if (!fault) fault_code <= FC_LOAD_OVF;
          end
        end
        ISSUE: begin
          if (redirect_valid) pc <= redirect_pc;
          else if (pc >= SIZE) begin
            fault <= 1'b1;
            if (!fault) fault_code <= FC_PC_RANGE;
          end
        end
        WAIT: begin
          if (redirect_valid) pc <= redirect_pc;
          else begin
            inst <= mem_rdata;
            inst_pc <= pc;
            if (mem_rdata == FILL_WORD) begin
              fault <= 1'b1;
              if (!fault) fault_code <= FC_FILL;
            end else inst_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) pc <= redirect_pc;
          else if (inst_ready) pc <= pc + 32'd1;
          if (redirect_valid || inst_ready) inst_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter MEM_SIZE, default 1024, instruction memory depth in 32-bit words.
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after start.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_req  input  1  IDLE/HALT request to enter program-load mode.
REQ-006 prog_valid, prog_ready, prog_data, prog_last  in/out/in/in  1/1/32/1  program-word stream, ready/valid.
REQ-007 start  input  1  IDLE/HALT request to begin fetching at RESET_PC.
REQ-008 redirect_valid, redirect_pc  input  1/32  branch/jump PC override.
REQ-009 mem_addr, mem_wdata, mem_load  output  32/32/1  drive instruction memory address, write data, write strobe.
REQ-010 mem_rdata  input  32  instruction memory registered read data, valid one cycle after mem_addr is sampled.
REQ-011 inst_valid, inst_ready, inst, inst_pc  out/in/out/out  1/1/32/32  fetched-instruction handshake to decode.
REQ-012 state, fault, fault_code  output  3/1/2  current FSM state, sticky fault flag, fault cause.

Function
REQ-013 FSM states IDLE, LOAD, ISSUE, WAIT, HOLD, HALT.
REQ-014 IDLE/HALT: load_req -> LOAD with load_ptr=0; else start -> ISSUE with pc=RESET_PC; load_req has priority; either exit clears fault and fault_code.
REQ-015 LOAD: prog_ready=1; handshake (prog_valid&prog_ready) drives mem_load=1, mem_addr=load_ptr, mem_wdata=prog_data combinationally in that cycle; load_ptr increments on each handshake.
REQ-016 LOAD exit: handshake with prog_last=1 -> IDLE; handshake at load_ptr==MEM_SIZE-1 with prog_last=0 -> IDLE, fault=1, fault_code=3 (overflow); that final word is still written.
REQ-017 mem_load=0 in every state except a LOAD handshake cycle; prog_ready=0 outside LOAD.
REQ-018 mem_addr = load_ptr in LOAD, pc otherwise.
REQ-019 ISSUE: if pc >= MEM_SIZE -> HALT, fault=1, fault_code=1, no instruction delivered; else -> WAIT.
REQ-020 WAIT: capture inst<=mem_rdata, inst_pc<=pc; if mem_rdata==FILL_WORD (32'hDEADBEEF) -> HALT, fault=1, fault_code=2, inst_valid stays 0; else inst_valid<=1, -> HOLD.
REQ-021 Latency: inst_valid rises exactly 2 cycles after entering ISSUE; throughput 1 instruction per 3 cycles minimum.
REQ-022 HOLD: inst_valid=1, inst/inst_pc stable until inst_ready=1; on handshake pc<=pc+1 (32-bit wrap), inst_valid<=0, -> ISSUE.
REQ-023 redirect_valid in ISSUE, WAIT or HOLD: pc<=redirect_pc, inst_valid<=0, -> ISSUE; redirect wins over a simultaneous inst handshake; the in-flight instruction is discarded.
REQ-024 redirect_valid, start and load_req are ignored in states where not listed above.
REQ-025 fault is sticky; fault_code holds the first cause until cleared per REQ-014 or reset.

Reset
REQ-026 reset asserted: state=IDLE, pc=RESET_PC, load_ptr=0, inst=0, inst_pc=0, inst_valid=0, fault=0, fault_code=0, immediately without waiting for clk.
REQ-027 reset mid-LOAD or mid-fetch abandons the operation; memory contents already written are not this block's concern.
REQ-028 Combinational outputs (prog_ready, mem_load) are 0 while reset is asserted.

Structure
REQ-029 Shared package fetch_pkg holds the state enum, fault_code constants (NONE=0, PC_RANGE=1, FILL=2, LOAD_OVF=3), FILL_WORD and default MEM_SIZE.
REQ-030 Single module, no sub-module; pc and load_ptr are local registers.

Verification
REQ-031 Load 4 words A0..A3 with prog_last on 4th -> 4 mem_load pulses at addr 0..3, return to IDLE, fault=0.
REQ-032 start, inst_ready=1 -> inst_pc 0,1,2,3 delivered, inst_valid first high 2 cycles after ISSUE, 3-cycle spacing; word at addr 4 = DEADBEEF -> HALT, fault_code=2.
REQ-033 inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc unchanged, pc not advanced.
REQ-034 redirect_valid with redirect_pc=2 coincident with inst handshake at pc=0 -> next inst_pc=2, pc 1 never delivered.
REQ-035 MEM_SIZE=8, load 8 words without prog_last -> fault_code=3; start with RESET_PC=8 -> HALT, fault_code=1.
REQ-036 reset asserted during WAIT mid-cycle -> state=IDLE, inst_valid=0 before next clk edge.
